// File: rtl/regfile_param_onehot_decoder.sv
// Enabled ADDR_W-to-2**ADDR_W one-hot decoder.
// It produces the per-register load strobes for the register file.
module onehot_decoder #(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0]      in,
   input  logic                   en,
   output logic [(2**ADDR_W)-1:0] out
);

   localparam int NOUT = 2 ** ADDR_W;

   always_comb begin
      out = '0;
      for (int i = 0; i < NOUT; i++) begin
         out[i] = en & (in == ADDR_W'(i));
      end
   end

endmodule

// File: rtl/regfile_param.sv
// General-purpose register file: NREGS x WIDTH, one synchronous write port and two combinational read ports.
// Register 0 reads as zero. An optional bypass forwards same-cycle write data to the read ports.
module regfile_param #(
   parameter int ADDR_W = 5,
   parameter int WIDTH  = 32,
   parameter int BYPASS = 1
) (
   input  logic              clock,
   input  logic              ctrl_reset_n,
   input  logic              ctrl_writeEnable,
   input  logic [ADDR_W-1:0] ctrl_writeReg,
   input  logic [WIDTH-1:0]  data_writeReg,
   input  logic [ADDR_W-1:0] ctrl_readRegA,
   input  logic [ADDR_W-1:0] ctrl_readRegB,
   output logic [WIDTH-1:0]  data_readRegA,
   output logic [WIDTH-1:0]  data_readRegB
);

   localparam int                NREGS     = 2 ** ADDR_W;
   localparam int                REG_ZERO  = 0;
   localparam logic [WIDTH-1:0]  RESET_VAL = '0;

   logic [NREGS-1:0] load_en;
   logic [WIDTH-1:0] rd_bank [NREGS];
   logic [WIDTH-1:0] stored_a;
   logic [WIDTH-1:0] stored_b;
   logic             wr_live;
   logic             hit_a;
   logic             hit_b;

   onehot_decoder #(
      .ADDR_W (ADDR_W)
   ) u_decoder (
      .in  (ctrl_writeReg),
      .en  (ctrl_writeEnable),
      .out (load_en)
   );

   // Register 0 has no storage; its bank slot is tied to the reset value.
   assign rd_bank[REG_ZERO] = RESET_VAL;

   for (genvar r = 1; r < NREGS; r++) begin : g_reg
      logic [WIDTH-1:0] q;

      always_ff @(posedge clock or negedge ctrl_reset_n) begin
         if (!ctrl_reset_n) begin
            q <= RESET_VAL;
         end else if (load_en[r]) begin
            q <= data_writeReg;
         end
      end

      assign rd_bank[r] = q;
   end

   assign stored_a = rd_bank[ctrl_readRegA];
   assign stored_b = rd_bank[ctrl_readRegB];

   // A write is live only when enabled and not aimed at register 0.
   // The bypass path ignores reset, so a live write is forwarded even while the array is held clear.
   assign wr_live = ctrl_writeEnable & ~load_en[REG_ZERO];
   assign hit_a   = (BYPASS != 0) && wr_live && (ctrl_readRegA == ctrl_writeReg);
   assign hit_b   = (BYPASS != 0) && wr_live && (ctrl_readRegB == ctrl_writeReg);

   assign data_readRegA = hit_a ? data_writeReg : stored_a;
   assign data_readRegB = hit_b ? data_writeReg : stored_b;

endmodule
